// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared widths, one-hot FSM states and saturation value for the CSA accumulator
package csa_pkg;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_ACCUM = 3'b010,
        S_DONE  = 3'b100
    } state_e;

    localparam logic [DATA_W-1:0] SAT_VALUE = 16'hFFFF;
endpackage

// File: rtl/csa_stream_accumulator_if.sv
// rtl/csa_stream_accumulator_if.sv - operand/result handshake bundle for the CSA accumulator
interface csa_stream_accumulator_if;
    import csa_pkg::*;

    logic              start;
    logic [CNT_W-1:0]  len;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_sum;
    logic              out_ovf;
    logic [CNT_W-1:0]  out_count;
    logic              out_valid;
    logic              out_ready;
    logic              busy;

    modport master (
        output start, len, in_data, in_valid, out_ready,
        input  in_ready, out_sum, out_ovf, out_count, out_valid, busy
    );

    modport slave (
        input  start, len, in_data, in_valid, out_ready,
        output in_ready, out_sum, out_ovf, out_count, out_valid, busy
    );
endinterface

// File: rtl/carry_select_adder.sv
// rtl/carry_select_adder.sv - 16-bit carry-select adder built from four 4-bit precomputed blocks
module carry_select_adder (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] sum_o,
    output logic        cout_o
);
    logic [4:0] carry;

    assign carry[0] = cin_i;

    for (genvar g = 0; g < 4; g++) begin : gen_blk
        logic [4:0] res0;
        logic [4:0] res1;
        // Both carry-in cases are formed up front; the incoming carry only drives the mux.
        assign res0 = {1'b0, a_i[4*g+3:4*g]} + {1'b0, b_i[4*g+3:4*g]};
        assign res1 = res0 + 5'd1;
        assign sum_o[4*g+3:4*g] = carry[g] ? res1[3:0] : res0[3:0];
        assign carry[g+1]       = carry[g] ? res1[4]   : res0[4];
    end

    assign cout_o = carry[4];
endmodule

// File: rtl/csa_stream_accumulator.sv
// rtl/csa_stream_accumulator.sv - burst accumulator over the carry-select adder; CSA_ACC_SATURATE_EN clamps on carry-out
module csa_stream_accumulator
    import csa_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    csa_stream_accumulator_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_e            state_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] acc_d;
    logic              ovf_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W-1:0]  len_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;
    logic [DATA_W-1:0] add_sum;
    logic              add_cout;
    logic              beat;

    carry_select_adder u_adder (
        .a_i    (acc_q),
        .b_i    (bus.in_data),
        .cin_i  (1'b0),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_comb begin
        acc_d = add_sum;
`ifdef CSA_ACC_SATURATE_EN
        if (add_cout) begin
            acc_d = SAT_VALUE;
        end
`else
`endif
        cnt_d = cnt_q + CNT_ONE;
        beat  = bus.in_valid & in_ready_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            len_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        len_q  <= bus.len;
                        acc_q  <= '0;
                        ovf_q  <= 1'b0;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        // A zero-length burst reports an empty result straight away.
                        if (bus.len == '0) begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q    <= S_ACCUM;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                S_ACCUM: begin
                    if (beat) begin
                        acc_q <= acc_d;
                        ovf_q <= ovf_q | add_cout;
                        cnt_q <= cnt_d;
                        if (cnt_d == len_q) begin
                            state_q     <= S_DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.out_sum   = out_valid_q ? acc_q : '0;
    assign bus.out_ovf   = out_valid_q & ovf_q;
    assign bus.out_count = out_valid_q ? cnt_q : '0;
endmodule

// File: tb/tb_csa_stream_accumulator.sv
// tb/tb_csa_stream_accumulator.sv - randomized self-checking bench for csa_stream_accumulator
module tb_csa_stream_accumulator;
    import csa_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    csa_stream_accumulator_if bus ();

    csa_stream_accumulator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] data_q[$];
    bit          ir_seen;

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.in_ready) ir_seen = 1'b1;
    endtask

    // Arithmetic reference: running integer sum, wrap or clamp whenever it passes 16 bits.
    function automatic void model(input int n, output logic [15:0] es, output logic eo);
        int s;
        s  = 0;
        eo = 1'b0;
        for (int i = 0; i < n; i++) begin
            s = s + int'(data_q[i]);
            if (s > 65535) begin
                eo = 1'b1;
`ifdef CSA_ACC_SATURATE_EN
                s = 65535;
`else
                s = s - 65536;
`endif
            end
        end
        es = 16'(s);
    endfunction

    task automatic do_burst(input int n, input int gap, input int hold, input bit extra,
                            output logic [15:0] sum, output logic ovf, output logic [7:0] cnt,
                            output int lat, output bit stable, output bit valid_after, output bit to);
        int g;
        to      = 1'b0;
        stable  = 1'b1;
        ir_seen = 1'b0;
        bus.start = 1'b1;
        bus.len   = 8'(n);
        tick();
        if (extra) bus.len = 8'd1;
        else       bus.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < gap; k++) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 16'($urandom);
                tick();
            end
            bus.in_valid = 1'b1;
            bus.in_data  = data_q[i];
            g = 0;
            while (!bus.in_ready && g < 50) begin
                tick();
                g++;
            end
            if (g >= 50) to = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 16'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        sum = bus.out_sum;
        ovf = bus.out_ovf;
        cnt = bus.out_count;
        for (int k = 0; k < hold; k++) begin
            tick();
            if (!bus.out_valid || bus.out_sum !== sum || bus.out_ovf !== ovf || bus.out_count !== cnt)
                stable = 1'b0;
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        valid_after   = bus.out_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", bus.busy); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b exp 0", bus.in_ready); end
        checks++; if ({bus.out_valid, bus.out_ovf, bus.out_sum, bus.out_count} !== 26'd0) begin
            errors++; $display("FAIL reset_outputs got %h exp 0", {bus.out_valid, bus.out_ovf, bus.out_sum, bus.out_count}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [15:0] s; logic o; logic [7:0] c; int lat; bit st, va, to;
        data_q = '{16'd1, 16'd2, 16'd3, 16'd4};
        do_burst(4, 0, 0, 1'b0, s, o, c, lat, st, va, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout got %0b exp 0", to); end
        checks++; if (s !== 16'd10) begin errors++; $display("FAIL basic_sum got %h exp %h", s, 16'd10); end
        checks++; if (o !== 1'b0) begin errors++; $display("FAIL basic_ovf got %0b exp 0", o); end
        checks++; if (c !== 8'd4) begin errors++; $display("FAIL basic_count got %0d exp 4", c); end
        checks++; if (lat !== 0) begin errors++; $display("FAIL basic_latency got %0d exp 0", lat); end
        checks++; if (va !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %0b exp 0", va); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] s; logic o; logic [7:0] c; int lat; bit st, va, to;
        data_q = '{16'h001F};
        do_burst(1, 0, 0, 1'b0, s, o, c, lat, st, va, to);
        checks++; if (s !== 16'h001F || c !== 8'd1) begin errors++; $display("FAIL b2b_first got %h/%0d exp 001f/1", s, c); end
        data_q = '{16'h001F, 16'h000C};
        do_burst(2, 0, 0, 1'b0, s, o, c, lat, st, va, to);
        checks++; if (s !== 16'h002B) begin errors++; $display("FAIL b2b_sum got %h exp 002b", s); end
        checks++; if (o !== 1'b0 || c !== 8'd2) begin errors++; $display("FAIL b2b_flags got %0b/%0d exp 0/2", o, c); end
    endtask

    task automatic test_overflow();
        logic [15:0] s; logic o; logic [7:0] c; int lat; bit st, va, to;
        logic [15:0] exp_s;
`ifdef CSA_ACC_SATURATE_EN
        exp_s = 16'hFFFF;
`else
        exp_s = 16'h0001;
`endif
        data_q = '{16'hFFFF, 16'h0002};
        do_burst(2, 0, 0, 1'b0, s, o, c, lat, st, va, to);
        checks++; if (s !== exp_s) begin errors++; $display("FAIL ovf_sum got %h exp %h", s, exp_s); end
        checks++; if (o !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b exp 1", o); end
    endtask

    task automatic test_zero_len();
        logic [15:0] s; logic o; logic [7:0] c; int lat; bit st, va, to;
        data_q = {};
        do_burst(0, 0, 2, 1'b0, s, o, c, lat, st, va, to);
        checks++; if (lat !== 0) begin errors++; $display("FAIL zero_latency got %0d exp 0", lat); end
        checks++; if ({s, o, c} !== 25'd0) begin errors++; $display("FAIL zero_result got %h exp 0", {s, o, c}); end
        checks++; if (ir_seen !== 1'b0) begin errors++; $display("FAIL zero_in_ready got %0b exp 0", ir_seen); end
    endtask

    task automatic test_gaps();
        logic [15:0] s, es; logic o, eo; logic [7:0] c; int lat; bit st, va, to;
        data_q = {};
        for (int i = 0; i < 4; i++) data_q.push_back(16'($urandom));
        model(4, es, eo);
        do_burst(4, 3, 5, 1'b1, s, o, c, lat, st, va, to);
        checks++; if (s !== es || o !== eo) begin errors++; $display("FAIL gaps_result got %h/%0b exp %h/%0b", s, o, es, eo); end
        checks++; if (c !== 8'd4) begin errors++; $display("FAIL gaps_count got %0d exp 4", c); end
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL gaps_stable got %0b exp 1", st); end
        checks++; if (va !== 1'b0) begin errors++; $display("FAIL gaps_valid_drop got %0b exp 0", va); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] s; logic o; logic [7:0] c; int lat; bit st, va, to;
        bus.start = 1'b1; bus.len = 8'd4;
        tick();
        bus.start = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 16'd5;
        tick();
        bus.in_data = 16'd6;
        tick();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({bus.busy, bus.in_ready, bus.out_valid} !== 3'b000) begin
            errors++; $display("FAIL midrst_ctrl got %b exp 000", {bus.busy, bus.in_ready, bus.out_valid}); end
        checks++; if ({bus.out_sum, bus.out_ovf, bus.out_count} !== 25'd0) begin
            errors++; $display("FAIL midrst_outputs got %h exp 0", {bus.out_sum, bus.out_ovf, bus.out_count}); end
        data_q = '{16'd7};
        do_burst(1, 0, 0, 1'b0, s, o, c, lat, st, va, to);
        checks++; if (s !== 16'd7 || c !== 8'd1) begin errors++; $display("FAIL midrst_new got %h/%0d exp 0007/1", s, c); end
    endtask

    task automatic test_random();
        logic [15:0] s, es; logic o, eo; logic [7:0] c; int lat; bit st, va, to; int n;
        for (int it = 0; it < 25; it++) begin
            n = int'($urandom_range(0, 8));
            data_q = {};
            for (int i = 0; i < n; i++)
                data_q.push_back($urandom_range(0, 1) ? 16'($urandom_range(0, 255)) : 16'($urandom));
            model(n, es, eo);
            do_burst(n, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     s, o, c, lat, st, va, to);
            checks++; if (s !== es || o !== eo || c !== 8'(n)) begin
                errors++; $display("FAIL rand_result it%0d got %h/%0b/%0d exp %h/%0b/%0d", it, s, o, c, es, eo, n); end
            checks++; if (lat !== 0 || to !== 1'b0 || st !== 1'b1 || va !== 1'b0) begin
                errors++; $display("FAIL rand_timing it%0d got lat%0d to%0b st%0b va%0b exp lat0 to0 st1 va0", it, lat, to, st, va); end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_zero_len();
        test_gaps();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
